// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit in front of a word-wide memory without byte enables
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t             state_q, state_d;
  logic               we_q, we_d;
  logic               uns_q, uns_d;
  logic               err_q, err_d;
  logic [1:0]         size_q, size_d;
  logic [ADDR_W+1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        word_q, word_d;

  // Address bits above the word index alias by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  logic        misaligned;
  logic [4:0]  shift;
  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merged;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    misaligned = (req_size == 2'b11) ||
                 ((req_size == SZ_HALF) && req_addr[0]) ||
                 ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    shift     = {addr_q[1:0], 3'b000};
    shifted   = word_q >> shift;
    byte_sel  = shifted[7:0];
    half_sel  = addr_q[1] ? word_q[31:16] : word_q[15:0];
    load_ext  = word_q;
    lane_mask = 32'hFFFF_FFFF;
    lane_data = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        load_ext  = {{24{~uns_q & byte_sel[7]}}, byte_sel};
        lane_mask = 32'h0000_00FF << shift;
        lane_data = {24'h0, wdata_q[7:0]} << shift;
      end
      SZ_HALF: begin
        load_ext  = {{16{~uns_q & half_sel[15]}}, half_sel};
        lane_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
        lane_data = {16'h0, wdata_q[15:0]} << {addr_q[1], 4'b0000};
      end
      default: begin
        load_ext  = word_q;
        lane_mask = 32'hFFFF_FFFF;
        lane_data = wdata_q;
      end
    endcase
    merged = (word_q & ~lane_mask) | (lane_data & lane_mask);
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    uns_d      = uns_q;
    err_d      = err_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word_d     = word_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_err   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_wdata  = 32'h0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          uns_d   = req_unsigned;
          size_d  = req_size;
          addr_d  = req_addr[ADDR_W+1:0];
          wdata_d = req_wdata;
          err_d   = misaligned;
          word_d  = 32'h0;
          if (misaligned)
            state_d = RESP;
          else if (req_we && (req_size == SZ_WORD))
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD: begin
        mem_read = 1'b1;
        word_d   = mem_rdata;
        state_d  = we_q ? WR : RESP;
      end
      WR: begin
        // Gated by rst_n so a reset arriving in this cycle drops the write.
        mem_write = rst_n;
        mem_wdata = merged;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (we_q || err_q) ? 32'h0 : load_ext;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = ~req_ready;
  assign mem_addr = addr_q[ADDR_W+1:2];

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a word-wide memory model
module tb_load_store_unit;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              busy;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  int          cyc;
  int          wr_cnt;
  int          rd_cnt;
  int          viol;
  logic [7:0]  last_waddr;
  logic [31:0] last_wdata;
  int          n_pass;
  int          n_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else
      n_pass++;
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && req_valid && req_ready) acc_q.push_back(cyc);
    if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_wdata;
    end
    if (mem_read) rd_cnt <= rd_cnt + 1;
  end

  // Scoreboard monitor: pops an expectation whenever a response appears.
  always @(negedge clk) begin
    if ((mem_read && mem_write) || (resp_valid && (mem_read || mem_write)) || (busy == req_ready))
      viol++;
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        int   a;
        e = exp_q.pop_front();
        a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        check("latency", cyc - a, e.lat);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    exp_t e;
    @(negedge clk);
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = lat;
    exp_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    drain();
  endtask

  int wr0, rd0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    cyc = 0; wr_cnt = 0; rd_cnt = 0; viol = 0; n_pass = 0; n_total = 0;
    last_waddr = 8'h0; last_wdata = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
    check("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;

    // Word store then word load
    wr0 = wr_cnt;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    check("t1_wr_cnt", wr_cnt - wr0, 1);
    check("t1_waddr", {24'b0, last_waddr}, 32'h4);
    check("t1_mem", mem[4], 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Byte lanes, sign/zero extension, byte RMW
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'h00000022, 1'b0, 2);
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFF80, 32'h0, 1'b0, 3);
    check("t2_wdata", last_wdata, 32'h11803344);
    issue(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'h00000080, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h00001180, 1'b0, 2);

    // Half store RMW
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hAABBCCDD, 32'h0, 1'b0, 2);
    wr0 = wr_cnt; rd0 = rd_cnt;
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234, 32'h0, 1'b0, 3);
    check("t3_wdata", last_wdata, 32'h1234CCDD);
    check("t3_rd_cnt", rd_cnt - rd0, 1);
    check("t3_wr_cnt", wr_cnt - wr0, 1);
    issue(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 32'hFFFFCCDD, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h0000CCDD, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'h000000CC, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'h00000012, 1'b0, 2);

    // Errors: no memory traffic
    wr0 = wr_cnt; rd0 = rd_cnt;
    issue(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, 2'b10, 1'b0, 32'h21, 32'h55555555, 32'h0, 1'b1, 1);
    check("t4_rd_cnt", rd_cnt - rd0, 0);
    check("t4_wr_cnt", wr_cnt - wr0, 0);

    // Address wrap: 0x420 aliases word 8
    issue(1'b0, 2'b10, 1'b0, 32'h420, 32'h0, 32'h1234CCDD, 1'b0, 2);

    // Reset during WR of a byte store
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h000000FF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_in_wr", {31'b0, mem_write}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_mem_write", {31'b0, mem_write}, 32'd0);
    check("t5_mem", mem[8], 32'h1234CCDD);
    rst_n = 1'b1;
    acc_q.delete();
    repeat (4) @(negedge clk);

    // req_valid held high: accepts only in IDLE
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.rdata = 32'h1234CCDD; e.err = 1'b0; e.lat = 2;
      exp_q.push_back(e);
    end
    rd0 = rd_cnt;
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h0; req_valid = 1'b1;
    repeat (7) @(posedge clk);
    #1 req_valid = 1'b0;
    drain();
    check("t6_rd_cnt", rd_cnt - rd0, 3);

    repeat (3) @(negedge clk);
    check("invariants", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
